// File: rtl/rad_cdc_mcp_bdrain.sv
// rad_cdc_mcp_bdrain: drains MCP receive words into a small FIFO and streams them out as valid/ready
module rad_cdc_mcp_bdrain #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             bdata,
  input  logic                         bvalid,
  output logic                         bload,
  output logic [WIDTH-1:0]             m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         almost_full,
  output logic [31:0]                  words_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr, r_rd;
  logic [LW-1:0]    r_level;
  logic [31:0]      r_cnt;
  logic             w_full, w_empty, w_push, w_pop;
  assign w_full      = r_level == LW'(DEPTH);
  assign w_empty     = r_level == '0;
  assign bload       = bvalid && !w_full && !rst;
  assign w_push      = bvalid && bload;
  assign w_pop       = !w_empty && m_ready;
  assign m_valid     = !w_empty;
  assign m_data      = m_valid ? r_mem[r_rd] : '0;
  assign level       = r_level;
  assign almost_full = r_level >= LW'(AFULL_LVL);
  assign words_cnt   = r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_push) r_cnt <= r_cnt + 32'd1;
      if (w_pop) r_rd <= r_rd + PW'(1);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= bdata;
  a_level_range: assert property (@(posedge clk) disable iff (rst) r_level <= LW'(DEPTH));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) w_pop |-> !w_empty);
  a_no_push_full: assert property (@(posedge clk) disable iff (rst) w_push |-> !w_full);
endmodule

// File: tb/tb_rad_cdc_mcp_bdrain.sv
// tb_rad_cdc_mcp_bdrain: directed table, reset corners and random traffic against a queue model
module tb_rad_cdc_mcp_bdrain;
  localparam int DEPTH = 4;
  logic       clk = 0, rst = 1;
  logic [7:0] bdata = 0;
  logic       bvalid = 0, m_ready = 0;
  logic       bload, m_valid, almost_full;
  logic [7:0] m_data;
  logic [2:0] level;
  logic [31:0] words_cnt;
  int checks = 0, errors = 0;
  logic [7:0] q[$];
  int unsigned cnt = 0;

  rad_cdc_mcp_bdrain #(.WIDTH(8), .DEPTH(DEPTH), .AFULL_LVL(3)) dut (
    .clk(clk), .rst(rst), .bdata(bdata), .bvalid(bvalid), .bload(bload),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .level(level),
    .almost_full(almost_full), .words_cnt(words_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // model advances by the transfer rules, using pre-edge state
  task automatic step();
    bit push, pop;
    push = !rst && bvalid && q.size() < DEPTH;
    pop  = !rst && m_ready && q.size() > 0;
    @(posedge clk);
    if (rst) begin
      q.delete();
      cnt = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(bdata);
        cnt++;
      end
    end
    #2;
  endtask

  task automatic cmp_model();
    chk("bload", bload, !rst && bvalid && q.size() < DEPTH);
    chk("m_valid", m_valid, q.size() > 0);
    chk("m_data", m_data, q.size() > 0 ? q[0] : 8'h00);
    chk("level", level, q.size());
    chk("almost_full", almost_full, q.size() >= 3);
    chk("words_cnt", words_cnt, cnt);
  endtask

  typedef struct {
    logic bv; logic [7:0] d; logic mr; logic eb;
    logic [2:0] lv; logic ev; logic [7:0] ed; logic ea; logic [31:0] ec;
  } vec_t;
  vec_t tbl[14];

  initial begin
    int pushed, cyc;
    tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 3'd1, 1'b1, 8'hA5, 1'b0, 32'd1};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 32'd1};
    tbl[2]  = '{1'b1, 8'h01, 1'b0, 1'b1, 3'd1, 1'b1, 8'h01, 1'b0, 32'd2};
    tbl[3]  = '{1'b1, 8'h02, 1'b0, 1'b1, 3'd2, 1'b1, 8'h01, 1'b0, 32'd3};
    tbl[4]  = '{1'b1, 8'h03, 1'b0, 1'b1, 3'd3, 1'b1, 8'h01, 1'b1, 32'd4};
    tbl[5]  = '{1'b1, 8'h04, 1'b0, 1'b1, 3'd4, 1'b1, 8'h01, 1'b1, 32'd5};
    tbl[6]  = '{1'b1, 8'h05, 1'b0, 1'b0, 3'd4, 1'b1, 8'h01, 1'b1, 32'd5};
    tbl[7]  = '{1'b1, 8'h05, 1'b1, 1'b0, 3'd3, 1'b1, 8'h02, 1'b1, 32'd5};
    tbl[8]  = '{1'b1, 8'h05, 1'b0, 1'b1, 3'd4, 1'b1, 8'h02, 1'b1, 32'd6};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd3, 1'b1, 8'h03, 1'b1, 32'd6};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 1'b1, 8'h04, 1'b0, 32'd6};
    tbl[11] = '{1'b1, 8'h10, 1'b1, 1'b1, 3'd2, 1'b1, 8'h05, 1'b0, 32'd7};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 1'b1, 8'h10, 1'b0, 32'd7};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 32'd7};

    // reset held with bvalid high
    bvalid = 1;
    #1;
    chk("rst_bload", bload, 0);
    step();
    step();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_level", level, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_cnt", words_cnt, 0);
    rst = 0;
    #1;
    chk("rel_bload", bload, 1);

    foreach (tbl[i]) begin
      bvalid = tbl[i].bv; bdata = tbl[i].d; m_ready = tbl[i].mr;
      #1;
      chk($sformatf("t%0d_bload", i), bload, tbl[i].eb);
      step();
      chk($sformatf("t%0d_level", i), level, tbl[i].lv);
      chk($sformatf("t%0d_m_valid", i), m_valid, tbl[i].ev);
      chk($sformatf("t%0d_m_data", i), m_data, tbl[i].ed);
      chk($sformatf("t%0d_afull", i), almost_full, tbl[i].ea);
      chk($sformatf("t%0d_cnt", i), words_cnt, tbl[i].ec);
    end

    // mid-stream asynchronous reset at level 3
    m_ready = 0;
    for (int i = 0; i < 3; i++) begin
      bvalid = 1; bdata = 8'(i + 8'h30);
      step();
    end
    #1;
    cmp_model();
    chk("pre_rst_level", level, 3);
    rst = 1;
    #1;
    chk("async_bload", bload, 0);
    chk("async_m_valid", m_valid, 0);
    chk("async_m_data", m_data, 0);
    chk("async_level", level, 0);
    chk("async_cnt", words_cnt, 0);
    q.delete(); cnt = 0;
    step();
    rst = 0;
    bvalid = 1; bdata = 8'h77;
    #1;
    cmp_model();
    step();
    bvalid = 0;
    #1;
    chk("post_rst_first", m_data, 8'h77);
    cmp_model();
    m_ready = 1;
    step();
    chk("post_rst_drain", level, 0);

    rst = 1;
    step();
    rst = 0;
    pushed = 0; cyc = 0;
    while ((pushed < 1000 || q.size() > 0) && cyc < 20000) begin
      bvalid = pushed < 1000 ? ($urandom_range(0, 3) != 0) : 1'b0;
      bdata = 8'($urandom);
      m_ready = $urandom_range(0, 1) == 1;
      #1;
      cmp_model();
      if (bvalid && q.size() < DEPTH) pushed++;
      step();
      cyc++;
    end
    chk("rand_timeout", cyc < 20000, 1);
    #1;
    cmp_model();
    chk("rand_words_cnt", words_cnt, 1000);
    chk("rand_empty", m_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
